// File: rtl/obi_mem_arbiter.sv
// Two-requester (fetch I / load-store D) arbiter onto a single OBI-style memory port.
// Optional macro ARB_ROUND_ROBIN_EN: alternate winners on contention instead of fixed D priority.
module obi_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_web,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_web,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic OWN_D = 1'b1;
  localparam logic OWN_I = 1'b0;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   win;
  logic   sel;
  logic   issue;
  logic   resp;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Contention goes to whoever was not granted last; last starts at I so D wins first.
  always_comb begin
    win = d_req ? OWN_D : OWN_I;
    if (i_req && d_req) win = ~last_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= OWN_I;
    else      last_q <= last_d;
  end
`else
  // Fixed priority: D always beats I; I may starve.
  always_comb begin
    win = d_req ? OWN_D : OWN_I;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      owner_q <= OWN_D;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    sel       = owner_q;
    issue     = 1'b0;
    resp      = 1'b0;
    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_web   = 1'b1;
    mem_wdata = '0;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    busy      = (state_q != S_IDLE);
`ifdef ARB_ROUND_ROBIN_EN
    last_d    = last_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          sel     = win;
          owner_d = win;
          issue   = 1'b1;
          state_d = mem_gnt ? S_RESP : S_ADDR;
        end
      end
      S_ADDR: begin
        issue = 1'b1;
        if (mem_gnt) state_d = S_RESP;
      end
      S_RESP: begin
        // A response is only ever accepted here; stray rvalid elsewhere is dropped.
        if (mem_rvalid) begin
          resp    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      mem_req = 1'b1;
      if (sel == OWN_D) begin
        mem_addr  = d_addr;
        mem_web   = d_web;
        mem_wdata = d_wdata;
      end else begin
        mem_addr  = i_addr;
        mem_web   = 1'b1;
        mem_wdata = '0;
      end
    end

    d_gnt = mem_gnt & mem_req & (sel == OWN_D);
    i_gnt = mem_gnt & mem_req & (sel == OWN_I);
`ifdef ARB_ROUND_ROBIN_EN
    if (mem_gnt && mem_req) last_d = sel;
`endif

    if (resp) begin
      if (owner_q == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = mem_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = mem_rdata;
      end
    end

    // Reset holds every output at its idle value regardless of pending requests.
    if (!rst) begin
      mem_req   = 1'b0;
      mem_addr  = '0;
      mem_web   = 1'b1;
      mem_wdata = '0;
      i_gnt     = 1'b0;
      d_gnt     = 1'b0;
      i_rvalid  = 1'b0;
      d_rvalid  = 1'b0;
      i_rdata   = '0;
      d_rdata   = '0;
      busy      = 1'b0;
    end
  end

endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Self-checking bench for obi_mem_arbiter: vector table, contention, spurious rvalid and reset sequences.
module tb_obi_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic          d_web;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_web;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  obi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_web(d_web), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_web(mem_web), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          is_d;
    logic          web;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int unsigned   gnt_dly;
    int unsigned   rv_dly;
    logic [DW-1:0] rdata;
  } vec_t;

  typedef struct {
    logic          is_d;
    logic [DW-1:0] rdata;
  } resp_t;

  resp_t       sb[$];
  resp_t       exp_r;
  vec_t        vecs[6];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_web = 1'b1; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},   64'(mem_req), 64'(0));
    check({tag, "_mem_web"},   64'(mem_web), 64'(1));
    check({tag, "_mem_addr"},  64'(mem_addr), 64'(0));
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(0));
    check({tag, "_gnts"},      64'({i_gnt, d_gnt}), 64'(0));
    check({tag, "_busy"},      64'(busy), 64'(0));
  endtask

  // Scoreboard: every rvalid pops one expected response; rdata must be zero otherwise.
  always @(negedge clk) begin
    if (i_rvalid || d_rvalid) begin
      if (sb.size() == 0) begin
        check("unexpected_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
      end else begin
        exp_r = sb.pop_front();
        check("rvalid_owner", 64'({d_rvalid, i_rvalid}), exp_r.is_d ? 64'(2'b10) : 64'(2'b01));
        check("rdata", 64'(exp_r.is_d ? d_rdata : i_rdata), 64'(exp_r.rdata));
        check("nonowner_rdata", 64'(exp_r.is_d ? i_rdata : d_rdata), 64'(0));
      end
    end else begin
      check("rdata_when_idle", {i_rdata, d_rdata}, 64'(0));
    end
  end

  // One transaction with the bench acting as memory; owner drops req after the first cycle.
  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    if (v.is_d) begin
      d_req = 1'b1; d_addr = v.addr; d_web = v.web; d_wdata = v.wdata; i_req = 1'b0;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
      d_req = 1'b0; d_addr = 32'h0000_0BAD; d_web = 1'b0; d_wdata = 32'hBAD0_BAD0;
    end
    mem_gnt = (v.gnt_dly == 0);
    for (int c = 0; c <= int'(v.gnt_dly); c++) begin
      @(negedge clk);
      check("mem_req",   64'(mem_req), 64'(1));
      check("mem_addr",  64'(mem_addr), 64'(v.addr));
      check("mem_web",   64'(mem_web), v.is_d ? 64'(v.web) : 64'(1));
      check("mem_wdata", 64'(mem_wdata), v.is_d ? 64'(v.wdata) : 64'(0));
      check("d_gnt",     64'(d_gnt), 64'(v.is_d && c == int'(v.gnt_dly)));
      check("i_gnt",     64'(i_gnt), 64'(!v.is_d && c == int'(v.gnt_dly)));
      if (c > 0) check("busy_addr", 64'(busy), 64'(1));
      if (c == int'(v.gnt_dly)) sb.push_back('{v.is_d, v.rdata});
      @(posedge clk); #1;
      mem_gnt = (c + 1 == int'(v.gnt_dly));
      i_req = 1'b0;
      d_req = 1'b0;
    end
    for (int r = 1; r <= int'(v.rv_dly); r++) begin
      mem_rvalid = (r == int'(v.rv_dly));
      mem_rdata  = (r == int'(v.rv_dly)) ? v.rdata : DW'($urandom());
      @(negedge clk);
      check("mem_req_resp", 64'(mem_req), 64'(0));
      check("busy_resp", 64'(busy), 64'(1));
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    @(negedge clk);
    check("busy_after", 64'(busy), 64'(0));
  endtask

  // Both requesters held high; memory grants immediately and responds next cycle.
  task automatic contention(input int n);
    logic exp_d;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_addr = 32'h20; d_web = 1'b1;
    mem_gnt = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp_d = RR ? (k % 2 == 0) : 1'b1;
      @(negedge clk);
      check("cont_d_gnt", 64'(d_gnt), 64'(exp_d));
      check("cont_i_gnt", 64'(i_gnt), 64'(!exp_d));
      check("cont_addr",  64'(mem_addr), exp_d ? 64'(32'h20) : 64'(32'h10));
      sb.push_back('{exp_d, 32'hC0DE_0000 + 32'(k)});
      @(posedge clk); #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0DE_0000 + 32'(k);
      @(negedge clk);
      check("cont_mem_req_resp", 64'(mem_req), 64'(0));
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = '0; mem_gnt = 1'b1;
    end
    mem_gnt = 1'b0; i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h0,         0, 2, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_55AA, 3, 1, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_4004, 32'hFFFF_0000, 1, 3, 32'h1234_5678};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_0204, 32'h0,         2, 1, 32'hA5A5_A5A5};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0008, 32'hCAFE_F00D, 0, 1, 32'h0};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         0, 1, 32'hFFFF_FFFF};

    // Reset with both requests and a grant present: outputs must stay idle.
    clear_inputs();
    rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h44; d_addr = 32'h88; d_wdata = 32'h77;
    d_web = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst0");
    @(negedge clk);
    check_reset_outputs("rst1");
    @(posedge clk); #1;
    clear_inputs();
    rst = 1'b1;

    contention(4);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Spurious rvalid in IDLE: ignored and no state change.
    @(posedge clk); #1;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_1234;
    @(negedge clk);
    check("spur_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
    check("spur_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check("spur_busy_after", 64'(busy), 64'(0));

    // Reset asserted while a load waits in ADDR.
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h3000; d_web = 1'b1;
    @(negedge clk);
    check("pre_rst_req", 64'(mem_req), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy), 64'(1));
    #1;
    rst = 1'b0;
    mem_gnt = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    check_reset_outputs("midrst_hold");
    rst = 1'b1;
    d_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_BEEF;
    @(negedge clk);
    check("late_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
    check("late_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    mem_rvalid = 1'b0; mem_rdata = '0;

    run_vec('{1'b1, 1'b1, 32'h0000_3000, 32'h0, 1, 1, 32'h0BAD_F00D});

    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
